if_id_queue: RTL

Parametrised instruction-fetch queue that replaces the single IF/ID pipeline register between the fetch stage and the decode stage. It combines a DEPTH-entry FIFO with the registered ID-side outputs, so IF can keep fetching while ID stalls. It keeps the existing stall, flush and bubble semantics: a bubble is a zero instruction, and a flush kills younger fetched instructions. The pipeline registers remain the only state visible to ID.

---
 rtl/if_id_queue_if.sv | 34 +++
 rtl/if_id_queue.sv | 109 ++++++++++
 2 files changed

// File: rtl/if_id_queue_if.sv
// IF/ID queue bundle: fetch-side push signals and decode-side outputs.
// Shared by the queue (slave) and whatever drives fetch/decode (master).
interface if_id_queue_if #(
  parameter int INST_W = 32,
  parameter int PC_W   = 32,
  parameter int DEPTH  = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic              IF_stall;
  logic              IF_flush;
  logic              ID_stall;
  logic [INST_W-1:0] IF_inst;
  logic [PC_W-1:0]   IF_PCnext;
  logic              IF_full;
  logic [INST_W-1:0] ID_inst;
  logic [PC_W-1:0]   ID_PCnext;
  logic              ID_valid;
  logic [CW-1:0]     count;

  modport master (
    output IF_stall, IF_flush, ID_stall,
    output IF_inst, IF_PCnext,
    input  IF_full, ID_inst, ID_PCnext,
    input  ID_valid, count
  );

  modport slave (
    input  IF_stall, IF_flush, ID_stall,
    input  IF_inst, IF_PCnext,
    output IF_full, ID_inst, ID_PCnext,
    output ID_valid, count
  );
endinterface

// File: rtl/if_id_queue.sv
// Fetch queue between IF and ID: DEPTH-entry FIFO feeding a registered
// ID output stage, with bypass when empty, flush and bubble insertion.
module if_id_queue #(
  parameter int INST_W = 32,
  parameter int PC_W   = 32,
  parameter int DEPTH  = 4
) (
  input logic          clk,
  input logic          rst,
  if_id_queue_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int EW = INST_W + PC_W;

  logic [EW-1:0]     mem_q [DEPTH];
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic              valid_q, valid_d;

  logic          full;
  logic          empty;
  logic          push;
  logic          wr_en;
  logic [EW-1:0] head;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign push  = !bus.IF_stall && !bus.IF_flush && !full;
  assign head  = mem_q[rd_ptr_q];

  assign bus.IF_full   = full;
  assign bus.ID_inst   = inst_q;
  assign bus.ID_PCnext = pc_q;
  assign bus.ID_valid  = valid_q;
  assign bus.count     = count_q;

  // Next state: flush, pop/bypass/bubble when ID advances, else enqueue
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    inst_d   = inst_q;
    pc_d     = pc_q;
    valid_d  = valid_q;
    wr_en    = 1'b0;
    if (bus.IF_flush) begin
      count_d  = '0;
      rd_ptr_d = wr_ptr_q;
      if (!bus.ID_stall) begin
        inst_d  = '0;
        valid_d = 1'b0;
      end
    end else if (!bus.ID_stall) begin
      if (!empty) begin
        inst_d   = head[EW-1:PC_W];
        pc_d     = head[PC_W-1:0];
        valid_d  = 1'b1;
        rd_ptr_d = rd_ptr_q + PW'(1);
        if (push) begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + PW'(1);
        end else begin
          count_d = count_q - CW'(1);
        end
      end else if (push) begin
        inst_d  = bus.IF_inst;
        pc_d    = bus.IF_PCnext;
        valid_d = 1'b1;
      end else begin
        inst_d  = '0;
        valid_d = 1'b0;
      end
    end else if (push) begin
      wr_en    = 1'b1;
      wr_ptr_d = wr_ptr_q + PW'(1);
      count_d  = count_q + CW'(1);
    end
  end

  // Control and ID output registers, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      inst_q   <= '0;
      pc_q     <= '0;
      valid_q  <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      inst_q   <= inst_d;
      pc_q     <= pc_d;
      valid_q  <= valid_d;
    end
  end

  // FIFO storage; contents need no reset since count gates every read
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      mem_q[wr_ptr_q] <= {bus.IF_inst, bus.IF_PCnext};
    end
  end
endmodule
